// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-in first-out buffer of DEPTH words, each WIDTH bits wide.
// The read data output is registered.
//
// Ports:
//   clk   - clock; all state updates on its rising edge
//   rst   - synchronous active-high reset (clears pointers, count and fout; storage is not cleared)
//   data  - write data, captured when a write is accepted
//   wr    - write request, one word per cycle while high
//   rd    - read request, one word per cycle while high
//   fout  - read data, updated on the edge where a read is accepted and held otherwise
//   full  - occupancy == DEPTH
//   empty - occupancy == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] fout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] fout_q, fout_d;
  logic             rd_acc, wr_acc;

  // full and empty are decoded only from the registered count, so there is no path from wr or rd.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign fout  = fout_q;

  // When the FIFO is full, a write is still accepted if a read in the same cycle frees a slot.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    fout_d  = fout_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);  // DEPTH is a power of two, so overflow is the wrap
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
      fout_d = mem_q[rptr_q];
    end
    if (wr_acc && !rd_acc)      count_d = count_q + (AW+1)'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      fout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      fout_q  <= fout_d;
    end
  end

  // Storage is never reset. A stale word cannot be read, because the count bounds every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data = '0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [WIDTH-1:0] fout;
  logic             full, empty;

  int errors = 0;
  int checks = 0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .wr(wr), .rd(rd),
    .fout(fout), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last word read out.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_fout = '0;
  bit               model_ok = 1'b0;

  always @(posedge clk) begin
    bit r_ok, w_ok;
    if (rst) begin
      q.delete();
      m_fout   = '0;
      model_ok = 1'b1;
    end else begin
      r_ok = rd && (q.size() > 0);
      w_ok = wr && ((q.size() < DEPTH) || r_ok);
      if (r_ok) m_fout = q.pop_front();
      if (w_ok) q.push_back(data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The compare process checks the DUT against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_fout", 32'(fout), 32'(m_fout));
      chk("model_full", 32'(full), 32'(q.size() == DEPTH));
      chk("model_empty", 32'(empty), 32'(q.size() == 0));
    end
  end

  task automatic step(input logic r, input logic w, input logic rdq, input logic [WIDTH-1:0] d);
    rst = r; wr = w; rd = rdq; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] exp_seq [6];

    // Reset
    step(1, 0, 0, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_fout", 32'(fout), 0);

    // Fill with 1..4
    step(0, 1, 0, 3'd1);
    chk("fill_empty0", 32'(empty), 0);
    step(0, 1, 0, 3'd2);
    step(0, 1, 0, 3'd3);
    chk("fill_notfull", 32'(full), 0);
    step(0, 1, 0, 3'd4);
    chk("fill_full", 32'(full), 1);

    // Overflow: a write while full with no read is ignored
    step(0, 1, 0, 3'd7);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_fout", 32'(fout), 0);

    // Drain for 5 cycles; the 5th read hits an empty FIFO and is ignored
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 0);
      chk("drain_fout", 32'(fout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(0, 0, 1, 0);
    chk("drain_hold", 32'(fout), 4);

    // Simultaneous read and write while full
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 3'(i));
    step(0, 1, 1, 3'd5);
    chk("simfull_fout", 32'(fout), 1);
    chk("simfull_full", 32'(full), 1);
    for (int i = 2; i <= 5; i++) begin
      step(0, 0, 1, 0);
      chk("simfull_drain", 32'(fout), 32'(i));
    end

    // Simultaneous read and write while empty: only the write is accepted
    step(0, 1, 1, 3'd6);
    chk("simempty_empty", 32'(empty), 0);
    chk("simempty_fout", 32'(fout), 5);
    step(0, 0, 1, 0);
    chk("simempty_read", 32'(fout), 6);

    // Interleave writes and reads across the pointer wrap
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    step(0, 1, 0, 3'd1);
    step(0, 1, 0, 3'd2);
    step(0, 0, 1, 0); chk("wrap_r1", 32'(fout), 32'(exp_seq[0]));
    step(0, 1, 0, 3'd3);
    step(0, 0, 1, 0); chk("wrap_r2", 32'(fout), 32'(exp_seq[1]));
    step(0, 1, 0, 3'd4);
    step(0, 1, 0, 3'd5);
    step(0, 0, 1, 0); chk("wrap_r3", 32'(fout), 32'(exp_seq[2]));
    step(0, 1, 0, 3'd6);
    step(0, 0, 1, 0); chk("wrap_r4", 32'(fout), 32'(exp_seq[3]));
    step(0, 0, 1, 0); chk("wrap_r5", 32'(fout), 32'(exp_seq[4]));
    step(0, 0, 1, 0); chk("wrap_r6", 32'(fout), 32'(exp_seq[5]));
    chk("wrap_empty", 32'(empty), 1);

    // Reset with 2 words stored; reset takes priority over wr and rd in the same cycle
    step(0, 1, 0, 3'd3);
    step(0, 1, 0, 3'd2);
    step(1, 1, 1, 3'd7);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_fout", 32'(fout), 0);
    step(0, 0, 1, 0);
    chk("midrst_rdempty", 32'(fout), 0);
    step(0, 1, 0, 3'd5);
    step(0, 0, 1, 0);
    chk("midrst_newdata", 32'(fout), 5);
    chk("midrst_empty2", 32'(empty), 1);

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 3, data word width in bits, SHALL be supported.
REQ-002 Parameter DEPTH, default 4, number of storage entries (power of two, >=2), SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data  input  WIDTH  write data, sampled on the clk edge where a write is accepted.
REQ-006 wr  input  1  write request, level-sensitive, one word per cycle while high.
REQ-007 rd  input  1  read request, level-sensitive, one word per cycle while high.
REQ-008 fout  output  WIDTH  registered read data.
REQ-009 full  output  1  high when occupancy == DEPTH.
REQ-010 empty  output  1  high when occupancy == 0.

Function
REQ-011 Storage SHALL be a DEPTH x WIDTH register array with write pointer, read pointer and occupancy counter (log2(DEPTH)+1 bits).
REQ-012 Write accepted = wr & (!full | rd_accepted); accepted write SHALL store data at mem[wptr] and increment wptr modulo DEPTH.
REQ-013 Read accepted = rd & !empty; accepted read SHALL load fout <= mem[rptr] and increment rptr modulo DEPTH.
REQ-014 Read latency SHALL be one cycle: fout shows the word on the clock edge the read is accepted, valid after it.
REQ-015 fout SHALL hold its last value when no read is accepted, including rd on empty.
REQ-016 Order SHALL be strict first-in first-out.
REQ-017 Occupancy: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-018 full and empty SHALL be registered or decoded from the counter with no combinational path from wr/rd.
REQ-019 wr while full without a simultaneous accepted read SHALL be ignored: no memory write, no pointer or count change.
REQ-020 rd while empty SHALL be ignored: no pointer or count change, fout unchanged.
REQ-021 wr & rd while empty SHALL accept only the write; no fall-through, fout unchanged.
REQ-022 wr & rd while full SHALL accept both; the read returns the oldest word, the write fills the freed slot, full stays high.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 without data loss.

Reset
REQ-024 When rst is high at a clk edge: wptr=0, rptr=0, count=0, empty=1, full=0, fout=0.
REQ-025 rst SHALL take priority over wr/rd in the same cycle.
REQ-026 Memory contents are not cleared by reset and SHALL never be visible until rewritten.
REQ-027 Reset mid-operation SHALL discard all stored words; the next read-after-write returns only post-reset data.

Verification
REQ-028 Reset: hold rst 1 cycle -> empty=1, full=0, fout=0.
REQ-029 Fill: write 1,2,3,4 on consecutive single-cycle wr pulses -> empty=0 after the first, full=1 after the fourth.
REQ-030 Drain: hold rd 5 cycles after the fill -> fout=1,2,3,4 on successive cycles; empty=1 after the fourth; fifth read ignored, fout stays 4.
REQ-031 Overflow: with full, wr with data 7 and rd=0 -> contents unchanged; subsequent drain returns 1,2,3,4.
REQ-032 Simultaneous: with full (1..4), wr=rd=1 with data 5 -> fout=1, full stays 1; drain returns 2,3,4,5. With empty, wr=rd=1 with data 6 -> empty=0, fout unchanged.
REQ-033 Wrap/reset: 6 writes interleaved with reads preserve order across the pointer wrap; rst asserted with 2 words stored -> empty=1, a later read returns only new data.
